// File: rtl/serial_subtractor_if.sv
// ----------------------------------------------------------------------------
// serial_subtractor_if
//   Bundles the start/busy/done handshake, the operands and the results of the
//   bit-serial subtractor.
//
//   Handshake:
//   - The requester raises start_i with a_i/b_i valid.
//   - The request is accepted on the first rising edge where the subtractor is
//     idle (busy_o low).
//   - busy_o is high from the cycle after acceptance through the done_o cycle.
//   - done_o pulses for exactly one cycle.
//   - diff_o/ovf_o are valid from the done_o cycle and hold until the next
//     done_o or reset.
//
//   Modports:
//     master : drives start_i, a_i, b_i; observes busy_o, done_o, diff_o, ovf_o
//     slave  : the subtractor side (directions mirrored)
// ----------------------------------------------------------------------------
interface serial_subtractor_if #(
    parameter int WIDTH = 8
) ();
    logic             start_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH:0]   diff_o;
    logic             ovf_o;

    modport master (
        output start_i, a_i, b_i,
        input  busy_o, done_o, diff_o, ovf_o
    );

    modport slave (
        input  start_i, a_i, b_i,
        output busy_o, done_o, diff_o, ovf_o
    );
endinterface

// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial subtractor: computes a_i - b_i one bit per clock, LSB first,
//   with a registered borrow.
//   - Result is {borrow, diff}, i.e. (a - b) mod 2^(WIDTH+1).
//   - done_o arrives WIDTH+1 cycles after the start is accepted.
//
//   Optional feature (macro SUB_SIGNED_OVF_EN):
//   - Defined: ovf_o reports signed overflow of the WIDTH-bit difference,
//     registered alongside diff_o.
//   - Undefined: ovf_o is tied low and no flop exists for it.
//
//   Ports:
//     clk_i       : clock, rising edge
//     rst_i       : synchronous reset, active-high
//     bus         : serial_subtractor_if.slave (start_i, a_i, b_i, busy_o,
//                   done_o, diff_o, ovf_o)
//     dbg_state_o : current FSM state (0 IDLE, 1 RUN, 2 DONE)
// ----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    serial_subtractor_if.slave    bus,
    output logic [1:0]            dbg_state_o
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               w_busy;
    logic               w_done;

    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-2:0]   r_res;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_br;
    logic [WIDTH:0]     r_diff;

    logic               w_a_bit;
    logic               w_b_bit;
    logic               w_d;
    logic               w_br_next;
    logic               w_last;
    logic [WIDTH-1:0]   w_shift;

    // Current bit pair is always at position 0 of the operand shift registers.
    assign w_a_bit   = r_a_sr[0];
    assign w_b_bit   = r_b_sr[0];
    assign w_d       = w_a_bit ^ w_b_bit ^ r_br;
    assign w_br_next = (~w_a_bit & w_b_bit) | (~(w_a_bit ^ w_b_bit) & r_br);
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

    // Result bits enter from the MSB side. r_res keeps only WIDTH-1 bits; the
    // final bit is combined in w_shift when the result is committed.
    assign w_shift   = {w_d, r_res};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next state and outputs ----------------
    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start_i) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_busy       = 1'b1;
                w_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_a_sr <= '0;
            r_b_sr <= '0;
            r_res  <= '0;
            r_cnt  <= '0;
            r_br   <= 1'b0;
            r_diff <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        r_a_sr <= bus.a_i;
                        r_b_sr <= bus.b_i;
                        r_cnt  <= '0;
                        r_br   <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_a_sr <= r_a_sr >> 1;
                    r_b_sr <= r_b_sr >> 1;
                    r_res  <= w_shift[WIDTH-1:1];
                    r_br   <= w_br_next;
                    r_cnt  <= r_cnt + 1'b1;
                    // The result is committed on the edge that enters DONE,
                    // so diff_o is already valid while done_o is high.
                    if (w_last) begin
                        r_diff <= {w_br_next, w_shift};
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SUB_SIGNED_OVF_EN
    logic r_ovf;

    // On the last RUN cycle the bits at position 0 are the operand sign bits
    // and w_d is the sign bit of the WIDTH-bit difference.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ovf <= 1'b0;
        end else if (r_state == S_RUN && w_last) begin
            r_ovf <= (w_a_bit ^ w_b_bit) & (w_a_bit ^ w_d);
        end
    end

    assign bus.ovf_o = r_ovf;
`else
    assign bus.ovf_o = 1'b0;
`endif

    assign bus.busy_o  = w_busy;
    assign bus.done_o  = w_done;
    assign bus.diff_o  = r_diff;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_serial_subtractor.sv
// ----------------------------------------------------------------------------
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor (WIDTH=8).
//   - Expected {ovf, diff} values come from integer arithmetic on the
//     operands and are queued when a request is issued.
//   - A monitor pops one entry per done_o pulse and compares.
//   - The macro SUB_SIGNED_OVF_EN selects the expected ovf_o behaviour.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_subtractor;

    localparam int W = 8;

    logic       clk_i;
    logic       rst_i;
    logic [1:0] dbg_state;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_total = 0;
    int n_bad   = 0;

    logic [W+1:0] exp_q[$];   // {ovf, diff}

    // ---------------- reference model ----------------
    function automatic logic [W+1:0] model(input int a, input int b);
        int d;
        int sa;
        int sb;
        int sd;
        logic ovf;
        logic [W:0] dv;
        d  = (a - b) & ((1 << (W + 1)) - 1);
        dv = d[W:0];
        ovf = 1'b0;
`ifdef SUB_SIGNED_OVF_EN
        sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
        sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
        sd = sa - sb;
        ovf = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
`else
        sa = 0;
        sb = 0;
        sd = sa - sb;
`endif
        return {ovf, dv};
    endfunction

    task automatic check(input string name, input int got, input int want);
        n_total++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    int busy_cnt = 0;

    initial begin
        logic [W+1:0] e;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                busy_cnt = 0;
            end else begin
                if (bus.busy_o) busy_cnt++;
                if (bus.done_o) begin
                    check("done_with_busy", int'(bus.busy_o), 1);
                    if (exp_q.size() == 0) begin
                        n_total++;
                        n_bad++;
                        $display("FAIL unexpected_done: diff=%0h queue empty", bus.diff_o);
                    end else begin
                        e = exp_q.pop_front();
                        check("diff", int'(bus.diff_o), int'(e[W:0]));
                        check("ovf", int'(bus.ovf_o), int'(e[W+1]));
                        check("busy_width", busy_cnt, W + 1);
                    end
                    busy_cnt = 0;
                end else if (!bus.busy_o) begin
                    busy_cnt = 0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Issues one request from an idle cycle; optionally pulses start_i again
    // with fresh operands at cycle 'glitch' of the run. Operand inputs are
    // scrambled after acceptance.
    task automatic run_op(input int a, input int b, input int glitch,
                          output int got_diff, output int got_ovf);
        bit seen;
        seen = 0;
        got_diff = -1;
        got_ovf  = -1;
        @(negedge clk_i);
        exp_q.push_back(model(a, b));
        bus.start_i = 1'b1;
        bus.a_i = W'(a);
        bus.b_i = W'(b);
        for (int i = 1; i <= 3 * W; i++) begin
            @(negedge clk_i);
            if (bus.done_o) begin
                check("latency", i, W + 1);
                got_diff = int'(bus.diff_o);
                got_ovf  = int'(bus.ovf_o);
                seen = 1;
                break;
            end
            bus.start_i = (i == glitch);
            bus.a_i = W'($urandom_range(0, (1 << W) - 1));
            bus.b_i = W'($urandom_range(0, (1 << W) - 1));
        end
        bus.start_i = 1'b0;
        if (!seen) begin
            n_total++;
            n_bad++;
            $display("FAIL timeout: no done_o for a=%0d b=%0d", a, b);
        end
    endtask

    // Waits for done_o with a cycle bound; returns cycles waited (-1 = timeout).
    task automatic wait_done(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 3 * W; i++) begin
            @(negedge clk_i);
            if (bus.done_o) begin
                cycles = i;
                break;
            end
        end
    endtask

    // Back-to-back requests with start_i held high. New operands are placed
    // during each done cycle so the next accept picks them up.
    task automatic sweep(input int n, input int mode);
        int a;
        int b;
        int cyc;
        int corner[6];
        corner = '{0, 1, 127, 128, 254, 255};
        @(negedge clk_i);
        for (int k = 0; k < n; k++) begin
            if (mode == 0) begin
                a = corner[k / 6];
                b = corner[k % 6];
            end else begin
                a = $urandom_range(0, (1 << W) - 1);
                b = $urandom_range(0, (1 << W) - 1);
            end
            exp_q.push_back(model(a, b));
            bus.a_i = W'(a);
            bus.b_i = W'(b);
            bus.start_i = 1'b1;
            wait_done(cyc);
            if (cyc < 0) begin
                n_total++;
                n_bad++;
                $display("FAIL sweep_timeout: op %0d", k);
                break;
            end
            if (k > 0) check("b2b_spacing", cyc, W + 2);
        end
        bus.start_i = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int d;
        int o;
        rst_i = 1'b1;
        bus.start_i = 1'b0;
        bus.a_i = '0;
        bus.b_i = '0;
        repeat (3) @(negedge clk_i);
        check("rst_busy", int'(bus.busy_o), 0);
        check("rst_done", int'(bus.done_o), 0);
        check("rst_diff", int'(bus.diff_o), 0);
        check("rst_ovf", int'(bus.ovf_o), 0);
        check("rst_state", int'(dbg_state), 0);
        rst_i = 1'b0;

        // Known answers
        run_op(200, 55, 0, d, o);
        check("kat_200_55", d, 'h091);
        run_op(55, 200, 0, d, o);
        check("kat_55_200", d, 'h16F);
        run_op(0, 1, 0, d, o);
        check("kat_0_1", d, 'h1FF);
        run_op(255, 0, 0, d, o);
        check("kat_255_0", d, 'h0FF);

        // Extra start during the run is ignored
        run_op(100, 37, 3, d, o);
        check("ignored_start", d, 'h03F);
        repeat (W + 4) @(negedge clk_i);   // a second done_o would hit an empty queue

        // Reset in the middle of a run
        @(negedge clk_i);
        bus.start_i = 1'b1;
        bus.a_i = W'(77);
        bus.b_i = W'(3);
        @(negedge clk_i);
        bus.start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("abort_busy", int'(bus.busy_o), 0);
        check("abort_done", int'(bus.done_o), 0);
        check("abort_diff", int'(bus.diff_o), 0);
        check("abort_state", int'(dbg_state), 0);
        rst_i = 1'b0;
        repeat (W + 4) @(negedge clk_i);
        run_op(10, 10, 0, d, o);
        check("kat_10_10", d, 0);

        // Signed overflow
        run_op('h80, 'h01, 0, d, o);
        check("kat_80_01", d, 'h07F);
`ifdef SUB_SIGNED_OVF_EN
        check("ovf_80_01", o, 1);
`else
        check("ovf_80_01", o, 0);
`endif
        run_op('h05, 'h03, 0, d, o);
        check("ovf_05_03", o, 0);

        // Back-to-back sweeps: all corner pairs, then random pairs
        sweep(36, 0);
        repeat (3) @(negedge clk_i);
        sweep(1500, 1);

        repeat (W + 4) @(negedge clk_i);
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
